// File: rtl/mem_arbiter.sv
// Round-robin arbiter/sequencer sharing one memory (registered read port, cons engine)
// among NUM_REQ requesters, with a watchdog that converts a stalled access into an error.
module mem_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    rq_valid,
    input  logic [NUM_REQ-1:0]    rq_is_cons,
    input  logic [12*NUM_REQ-1:0] rq_addr,
    input  logic [16*NUM_REQ-1:0] rq_car,
    input  logic [16*NUM_REQ-1:0] rq_cdr,
    output logic [NUM_REQ-1:0]    rq_ready,
    output logic [NUM_REQ-1:0]    rsp_valid,
    output logic [15:0]           rsp_data,
    output logic                  rsp_err,
    output logic                  mem_req,
    output logic [11:0]           mem_addr,
    input  logic                  mem_data_ready,
    input  logic [15:0]           mem_data,
    output logic                  mem_cons_en,
    output logic [15:0]           mem_cons_car,
    output logic [15:0]           mem_cons_cdr,
    input  logic                  mem_cons_done,
    input  logic [15:0]           mem_cons_ptr,
    output logic                  busy
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

    typedef enum logic [1:0] {IDLE, RD_WAIT, CONS_WAIT, RESP} state_t;

    state_t          state_r;
    logic [IW-1:0]   last_grant_r;
    logic [IW-1:0]   gnt_r;
    logic [WW-1:0]   wdog_r;
    logic            err_r;

    logic            win_found_s;
    logic [IW-1:0]   win_idx_s;
    logic            win_cons_s;
    logic [11:0]     win_addr_s;
    logic [15:0]     win_car_s;
    logic [15:0]     win_cdr_s;
    int              dist_s;
    int              best_dist_s;

    // Winner = requesting index at smallest rotational distance past last_grant.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = '0;
        win_cons_s  = 1'b0;
        win_addr_s  = 12'd0;
        win_car_s   = 16'd0;
        win_cdr_s   = 16'd0;
        dist_s      = 0;
        best_dist_s = NUM_REQ;
        for (int i = 0; i < NUM_REQ; i++) begin
            dist_s = (i + 2 * NUM_REQ - int'(last_grant_r) - 1) % NUM_REQ;
            if (rq_valid[i] && (dist_s < best_dist_s)) begin
                best_dist_s = dist_s;
                win_found_s = 1'b1;
                win_idx_s   = i[IW-1:0];
                win_cons_s  = rq_is_cons[i];
                win_addr_s  = rq_addr[i*12 +: 12];
                win_car_s   = rq_car[i*16 +: 16];
                win_cdr_s   = rq_cdr[i*16 +: 16];
            end else begin
                best_dist_s = best_dist_s;
            end
        end
    end

    // Transaction FSM; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            last_grant_r <= IW'(NUM_REQ - 1);
            gnt_r        <= '0;
            wdog_r       <= '0;
            err_r        <= 1'b0;
            rq_ready     <= '0;
            rsp_valid    <= '0;
            rsp_data     <= 16'd0;
            rsp_err      <= 1'b0;
            mem_req      <= 1'b0;
            mem_addr     <= 12'd0;
            mem_cons_en  <= 1'b0;
            mem_cons_car <= 16'd0;
            mem_cons_cdr <= 16'd0;
            busy         <= 1'b0;
        end else begin
            rq_ready    <= '0;
            rsp_valid   <= '0;
            rsp_err     <= 1'b0;
            mem_req     <= 1'b0;
            mem_cons_en <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (win_found_s) begin
                        rq_ready     <= ONE_HOT0 << win_idx_s;
                        gnt_r        <= win_idx_s;
                        last_grant_r <= win_idx_s;
                        wdog_r       <= '0;
                        busy         <= 1'b1;
                        if (win_cons_s) begin
                            mem_cons_en  <= 1'b1;
                            mem_cons_car <= win_car_s;
                            mem_cons_cdr <= win_cdr_s;
                            state_r      <= CONS_WAIT;
                        end else begin
                            mem_req  <= 1'b1;
                            mem_addr <= win_addr_s;
                            state_r  <= RD_WAIT;
                        end
                    end else begin
                        busy <= 1'b0;
                    end
                end
                RD_WAIT: begin
                    if (mem_data_ready) begin
                        rsp_data <= mem_data;
                        err_r    <= 1'b0;
                        state_r  <= RESP;
                    end else if (wdog_r == WW'(TIMEOUT - 1)) begin
                        rsp_data <= 16'd0;
                        err_r    <= 1'b1;
                        state_r  <= RESP;
                    end else begin
                        wdog_r <= wdog_r + 1'b1;
                    end
                end
                CONS_WAIT: begin
                    if (mem_cons_done) begin
                        rsp_data <= mem_cons_ptr;
                        err_r    <= 1'b0;
                        state_r  <= RESP;
                    end else if (wdog_r == WW'(TIMEOUT - 1)) begin
                        rsp_data <= 16'd0;
                        err_r    <= 1'b1;
                        state_r  <= RESP;
                    end else begin
                        wdog_r <= wdog_r + 1'b1;
                    end
                end
                RESP: begin
                    rsp_valid <= ONE_HOT0 << gnt_r;
                    rsp_err   <= err_r;
                    busy      <= 1'b0;
                    state_r   <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a behavioural memory (registered read, two-cycle cons
// allocator starting at 0x006) plus table-driven single transactions and multi-cycle sequences.
module tb_mem_arbiter;
    localparam int NUM_REQ = 2;
    localparam int TIMEOUT = 15;
    localparam logic [2:0] TYPE_CONS = 3'd1;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NUM_REQ-1:0]    rq_valid, rq_is_cons, rq_ready, rsp_valid;
    logic [12*NUM_REQ-1:0] rq_addr;
    logic [16*NUM_REQ-1:0] rq_car, rq_cdr;
    logic [15:0]           rsp_data, mem_data, mem_cons_car, mem_cons_cdr, mem_cons_ptr;
    logic                  rsp_err, mem_req, mem_data_ready, mem_cons_en, mem_cons_done, busy;
    logic [11:0]           mem_addr;

    mem_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .rq_valid(rq_valid), .rq_is_cons(rq_is_cons), .rq_addr(rq_addr),
        .rq_car(rq_car), .rq_cdr(rq_cdr), .rq_ready(rq_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_data_ready(mem_data_ready),
        .mem_data(mem_data), .mem_cons_en(mem_cons_en), .mem_cons_car(mem_cons_car),
        .mem_cons_cdr(mem_cons_cdr), .mem_cons_done(mem_cons_done),
        .mem_cons_ptr(mem_cons_ptr), .busy(busy)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    logic withhold = 1'b0;
    logic excl_viol = 1'b0;

    // Memory model
    logic [15:0] mem_words [0:4095];
    logic        cons_stage;
    logic [11:0] free_ptr;

    initial begin
        for (int a = 0; a < 4096; a++) mem_words[a] = 16'h0000;
        mem_words[1] = 16'hBEEF;
        mem_words[2] = 16'hDEAD;
        mem_words[3] = 16'h1234;
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            mem_data_ready <= 1'b0;
            mem_data       <= 16'h0000;
            cons_stage     <= 1'b0;
            mem_cons_done  <= 1'b0;
            mem_cons_ptr   <= 16'h0000;
            free_ptr       <= 12'h006;
        end else begin
            mem_data_ready <= mem_req && !withhold;
            if (mem_req) mem_data <= mem_words[mem_addr];
            cons_stage    <= mem_cons_en;
            mem_cons_done <= cons_stage;
            if (cons_stage) begin
                mem_cons_ptr <= {1'b0, TYPE_CONS, free_ptr};
                free_ptr     <= free_ptr + 12'd2;
            end
        end
    end

    always @(negedge clk) begin
        if (mem_req && mem_cons_en) excl_viol <= 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic wait_ready(input string name, output int t, output logic ok);
        ok = 1'b0;
        t  = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (|rq_ready) begin
                ok = 1'b1;
                t  = cyc;
                return;
            end
        end
        chk({name, "_ready_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_rsp(input string name, output int t, output logic ok);
        ok = 1'b0;
        t  = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (|rsp_valid) begin
                ok = 1'b1;
                t  = cyc;
                return;
            end
        end
        chk({name, "_rsp_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic set_req(input int id, input logic v, input logic c, input logic [11:0] a,
                           input logic [15:0] car, input logic [15:0] cdr);
        rq_valid[id]          = v;
        rq_is_cons[id]        = c;
        rq_addr[id*12 +: 12]  = a;
        rq_car[id*16 +: 16]   = car;
        rq_cdr[id*16 +: 16]   = cdr;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst        = 1'b1;
        rq_valid   = '0;
        rq_is_cons = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        string       name;
        int          id;
        logic        is_cons;
        logic [11:0] addr;
        logic [15:0] car;
        logic [15:0] cdr;
        logic [15:0] exp_data;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    task automatic run_vec(input vec_t v);
        int   t_acc, t_rsp;
        logic ok;
        @(negedge clk);
        set_req(v.id, 1'b1, v.is_cons, v.addr, v.car, v.cdr);
        wait_ready(v.name, t_acc, ok);
        if (ok) begin
            chk({v.name, "_ready"}, 32'(rq_ready), 32'(2'b01 << v.id));
            chk({v.name, "_mem_req"}, 32'(mem_req), 32'(!v.is_cons));
            chk({v.name, "_cons_en"}, 32'(mem_cons_en), 32'(v.is_cons));
            if (v.is_cons) chk({v.name, "_car"}, 32'(mem_cons_car), 32'(v.car));
            else           chk({v.name, "_addr"}, 32'(mem_addr), 32'(v.addr));
        end
        rq_valid[v.id] = 1'b0;
        wait_rsp(v.name, t_rsp, ok);
        if (ok) begin
            chk({v.name, "_rsp_valid"}, 32'(rsp_valid), 32'(2'b01 << v.id));
            chk({v.name, "_data"}, 32'(rsp_data), 32'(v.exp_data));
            chk({v.name, "_err"}, 32'(rsp_err), 32'(v.exp_err));
            chk({v.name, "_latency"}, 32'(t_rsp - t_acc), 32'(v.exp_lat));
        end
    endtask

    vec_t vecs [5];

    initial begin
        int   t_acc, t_rsp, t_prev;
        logic ok;

        rst = 1'b1; rq_valid = '0; rq_is_cons = '0; rq_addr = '0; rq_car = '0; rq_cdr = '0;

        vecs[0] = '{"rd0_beef",  0, 1'b0, 12'h001, 16'h0000, 16'h0000, 16'hBEEF, 1'b0, 3};
        vecs[1] = '{"cons1_a",   1, 1'b1, 12'h000, 16'h0002, 16'h0001, 16'h1006, 1'b0, 4};
        vecs[2] = '{"cons1_b",   1, 1'b1, 12'h000, 16'h0003, 16'h0004, 16'h1008, 1'b0, 4};
        vecs[3] = '{"rd1_1234",  1, 1'b0, 12'h003, 16'h0000, 16'h0000, 16'h1234, 1'b0, 3};
        vecs[4] = '{"cons0_c",   0, 1'b1, 12'h000, 16'h0005, 16'h0006, 16'h100A, 1'b0, 4};

        repeat (3) @(negedge clk);
        chk("rst_ready",     32'(rq_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_misc",      32'({rsp_err, mem_req, mem_cons_en, busy}), 32'd0);
        chk("rst_data",      32'({rsp_data, mem_addr}), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Two requesters continuously reading 0x002: grants must alternate 0,1,0,1
        do_reset();
        set_req(0, 1'b1, 1'b0, 12'h002, 16'h0000, 16'h0000);
        set_req(1, 1'b1, 1'b0, 12'h002, 16'h0000, 16'h0000);
        t_prev = 0;
        for (int g = 0; g < 4; g++) begin
            wait_ready("rr", t_acc, ok);
            if (ok) begin
                chk("rr_grant", 32'(rq_ready), 32'(2'b01 << (g % 2)));
                if (g > 0) chk("rr_interval", 32'(t_acc - t_prev), 32'd4);
                t_prev = t_acc;
            end
            wait_rsp("rr", t_rsp, ok);
            if (ok) begin
                chk("rr_rsp_id", 32'(rsp_valid), 32'(2'b01 << (g % 2)));
                chk("rr_data", 32'(rsp_data), 32'hDEAD);
            end
        end
        rq_valid = '0;

        // Watchdog: memory withholds data_ready
        do_reset();
        withhold = 1'b1;
        run_vec('{"wdog", 0, 1'b0, 12'h001, 16'h0000, 16'h0000, 16'h0000, 1'b1, TIMEOUT + 1});
        withhold = 1'b0;
        run_vec('{"post_wdog", 0, 1'b0, 12'h001, 16'h0000, 16'h0000, 16'hBEEF, 1'b0, 3});

        // Reset while in CONS_WAIT abandons the transaction
        do_reset();
        @(negedge clk);
        set_req(0, 1'b1, 1'b1, 12'h000, 16'h0007, 16'h0008);
        wait_ready("rst_mid", t_acc, ok);
        rq_valid = '0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_outs", 32'({rq_ready, rsp_valid, rsp_err, mem_req, mem_cons_en, busy}), 32'd0);
        chk("rst_mid_data", 32'({rsp_data, mem_addr}), 32'd0);
        chk("rst_mid_cons", 32'({mem_cons_car, mem_cons_cdr}), 32'd0);
        rst = 1'b0;
        ok = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (|rsp_valid) ok = 1'b1;
        end
        chk("rst_mid_no_rsp", 32'(ok), 32'd0);
        run_vec('{"cons_after_rst", 0, 1'b1, 12'h000, 16'h0002, 16'h0001, 16'h1006, 1'b0, 4});

        // last_grant=0: req0 read and req1 cons pending together -> req1 first
        @(negedge clk);
        set_req(0, 1'b1, 1'b0, 12'h001, 16'h0000, 16'h0000);
        set_req(1, 1'b1, 1'b1, 12'h000, 16'h0009, 16'h000A);
        wait_ready("mix1", t_acc, ok);
        if (ok) chk("mix1_grant", 32'(rq_ready), 32'b10);
        rq_valid[1] = 1'b0;
        wait_rsp("mix1", t_rsp, ok);
        if (ok) begin
            chk("mix1_rsp_id", 32'(rsp_valid), 32'b10);
            chk("mix1_data", 32'(rsp_data), 32'h1008);
        end
        wait_ready("mix0", t_acc, ok);
        if (ok) chk("mix0_grant", 32'(rq_ready), 32'b01);
        rq_valid[0] = 1'b0;
        wait_rsp("mix0", t_rsp, ok);
        if (ok) begin
            chk("mix0_rsp_id", 32'(rsp_valid), 32'b01);
            chk("mix0_data", 32'(rsp_data), 32'hBEEF);
            chk("mix0_err", 32'(rsp_err), 32'd0);
        end

        repeat (2) @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("mem_exclusive", 32'(excl_viol), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Round-robin arbiter and sequencer that shares the single memory block (one registered read port, one two-cycle cons-write engine) between NUM_REQ requesters, such as the evaluator, printer and reader.
- Accepts one transaction at a time: a word read or a cons allocation.
- Drives the memory handshake, waits for completion, and returns the data or cons pointer to the winning requester.
- Includes a watchdog that turns a stalled memory transaction into an error response.

Parameters:
NUM_REQ, 2, number of requesters (2..4)
TIMEOUT, 15, cycles allowed in a wait state before an error response is returned

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
rq_valid  in  NUM_REQ  per-requester request; held with its operands until rq_ready
rq_is_cons  in  NUM_REQ  1 = cons allocation, 0 = read
rq_addr  in  12*NUM_REQ  read address, requester i in bits [12i+11:12i]
rq_car  in  16*NUM_REQ  cons CAR word
rq_cdr  in  16*NUM_REQ  cons CDR word
rq_ready  out  NUM_REQ  one-hot, 1-cycle pulse: request accepted
rsp_valid  out  NUM_REQ  one-hot, 1-cycle pulse: response for requester i
rsp_data  out  16  read word or tagged cons pointer
rsp_err  out  1  qualifies rsp_valid: watchdog expired
mem_req  out  1  to memory req
mem_addr  out  12  to memory addr_in
mem_data_ready  in  1  from memory data_ready
mem_data  in  16  from memory data_out
mem_cons_en  out  1  to memory cons_en
mem_cons_car  out  16  to memory cons_car
mem_cons_cdr  out  16  to memory cons_cdr
mem_cons_done  in  1  from memory cons_done
mem_cons_ptr  in  16  from memory cons_ptr
busy  out  1  high in every state except IDLE

Behaviour:
- All outputs are registered. The reset value of every output is 0.
- Reset clears the FSM to IDLE, clears the watchdog, and sets the RR pointer so requester 0 has highest priority.
- Reset mid-transaction abandons the transaction with no response. Memory shares rst, so both sides return to idle together.
- States: IDLE, RD_WAIT, CONS_WAIT, RESP.
- IDLE:
  - If any rq_valid is set, select the winner as the first set bit scanning from (last_grant+1) mod NUM_REQ upward with wrap.
  - Latch the winner's operands and pulse rq_ready[winner].
  - Read: mem_req=1 for exactly one cycle, mem_addr=addr; go to RD_WAIT.
  - Cons: mem_cons_en=1 for exactly one cycle, drive car/cdr; go to CONS_WAIT.
  - Update last_grant to the winner.
- RD_WAIT: on mem_data_ready, capture mem_data into rsp_data; go to RESP.
- CONS_WAIT: on mem_cons_done, capture mem_cons_ptr into rsp_data; go to RESP.
- RESP: rsp_valid[granted]=1 for one cycle; go to IDLE.
- mem_addr, mem_cons_car and mem_cons_cdr hold their latched values until the next accept.
- Latency, with acceptance at edge T:
  - Read: mem_req high T..T+1, data_ready T+1..T+2, rsp_valid T+3..T+4.
  - Cons: cons_en T..T+1, cons_done T+2..T+3, rsp_valid T+4..T+5.
  - Sustained throughput: one read per 4 cycles, one cons per 5 cycles.
- Watchdog:
  - Counts cycles in RD_WAIT/CONS_WAIT and resets to 0 on entry.
  - On reaching TIMEOUT, go to RESP with rsp_err=1 and rsp_data=0.
  - rsp_err is 0 on all normal responses.
- Arbitration is only evaluated in IDLE. rq_valid changes in other states are ignored.
- A requester may re-assert rq_valid in the same cycle as its rsp_valid. It is considered at the next IDLE.
- Dropping rq_valid before rq_ready is a protocol violation; the block is not required to tolerate it.
- Simultaneous rq_valid on several requesters: exactly one rq_ready per accept, and no requester starves. Each is served within NUM_REQ transactions.
- Spurious mem_data_ready or mem_cons_done while in IDLE or RESP is ignored.
- At most one of mem_req and mem_cons_en is high in any cycle.

Test Plan:
1. Memory preloaded with word[1]=0xBEEF. Req0 reads addr 0x001 -> rq_ready[0] at T, rsp_valid[0] at T+3, rsp_data=0xBEEF, rsp_err=0.
2. After reset, req1 issues cons car=0x0002, cdr=0x0001 -> rsp_valid[1] at T+4, rsp_data[11:0]=0x006, rsp_data[14:12]=TYPE_CONS. A second cons returns [11:0]=0x008.
3. Req0 and req1 hold continuous reads of addr 0x002 -> grants alternate 0,1,0,1 starting with 0 after reset; every response is 0xDEAD and goes to the correct requester.
4. Memory model withholds mem_data_ready -> rsp_valid with rsp_err=1 and rsp_data=0 after TIMEOUT cycles in RD_WAIT. The next request completes normally.
5. Assert rst in CONS_WAIT -> all outputs 0 the next cycle and no rsp_valid. A subsequent cons from req0 returns [11:0]=0x006.
6. Req0 read and req1 cons pending together, with last_grant=0 -> req1 is served first (cons ptr), then req0 (read data). mem_req and mem_cons_en are never high in the same cycle.
